// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and the clock/baud constants
// used by both the scheduler and the byte transmitter.
package uart_pkg;

  localparam int unsigned FCLK = 50000000;
  localparam int unsigned VEL  = 57600;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    CHK  = 3'd4,
    GAP  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side byte-stream bundle for uart_tx_sched: per-requester valid/data/last
// from the sources, ready and packet grant back from the scheduler.
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_dat;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;

  modport master (
    output req_valid, req_dat, req_last,
    input  req_ready, grant
  );

  modport slave (
    input  req_valid, req_dat, req_last,
    output req_ready, grant
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of req at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one byte-serial UART transmitter.
// Optional checksum frame per packet: define UART_TX_SCHED_CHKSUM_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned GAP_TACTS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_sched_if.slave        req,
  output logic                  tx_st,
  output logic [7:0]            tx_dat,
  input  logic                  tx_busy,
  input  logic                  tx_ce_tact,
  input  logic                  tx_ce_stop,
  output logic                  pkt_done
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GW = 4;

  sched_state_e      state, state_n;
  logic [IW-1:0]     ptr, ptr_n, gidx, gidx_n;
  logic [N_REQ-1:0]  grant_q, grant_n, ready_q, ready_n;
  logic [7:0]        dat_q, dat_n;
  logic              last_q, last_n;
  logic              st_q, st_n, done_q, done_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic              enter_gap;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [7:0]        cur_byte;
`ifdef UART_TX_SCHED_CHKSUM_EN
  logic [7:0]        chk_q, chk_n;
  logic              chk_sent, chk_sent_n;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req.req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign cur_byte      = req.req_dat[{gidx, 3'b000} +: 8];
  assign req.req_ready = ready_q;
  assign req.grant     = grant_q;
  assign tx_st         = st_q;
  assign tx_dat        = dat_q;
  assign pkt_done      = done_q;

  // Next-state and registered-output logic; tx_st is high for the whole SEND cycle
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gidx_n    = gidx;
    grant_n   = grant_q;
    ready_n   = '0;
    dat_n     = dat_q;
    last_n    = last_q;
    st_n      = 1'b0;
    done_n    = 1'b0;
    gcnt_n    = gcnt;
    enter_gap = 1'b0;
`ifdef UART_TX_SCHED_CHKSUM_EN
    chk_n      = chk_q;
    chk_sent_n = chk_sent;
`endif
    case (state)
      IDLE: begin
        if (!tx_busy && pick_found) begin
          gidx_n  = pick_idx;
          grant_n = N_REQ'(1) << pick_idx;
          state_n = LOAD;
`ifdef UART_TX_SCHED_CHKSUM_EN
          chk_n      = 8'h00;
          chk_sent_n = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (req.req_valid[gidx]) begin
          ready_n = grant_q;
          dat_n   = cur_byte;
          last_n  = req.req_last[gidx];
          st_n    = 1'b1;
          state_n = SEND;
`ifdef UART_TX_SCHED_CHKSUM_EN
          chk_n = chk_q ^ cur_byte;
`endif
        end
      end
      SEND: state_n = WAIT;
      WAIT: begin
        if (tx_ce_stop) begin
          if (!last_q) begin
            state_n = LOAD;
          end else begin
`ifdef UART_TX_SCHED_CHKSUM_EN
            if (chk_sent) enter_gap = 1'b1;
            else          state_n   = CHK;
`else
            enter_gap = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_SCHED_CHKSUM_EN
      CHK: begin
        dat_n      = chk_q;
        last_n     = 1'b1;
        chk_sent_n = 1'b1;
        st_n       = 1'b1;
        state_n    = SEND;
      end
`endif
      GAP: begin
        if (GAP_TACTS == 0) begin
          state_n = IDLE;
        end else if (tx_ce_tact) begin
          if (gcnt == GW'(GAP_TACTS - 1)) state_n = IDLE;
          else                            gcnt_n  = gcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (enter_gap) begin
      done_n  = 1'b1;
      grant_n = '0;
      gcnt_n  = '0;
      ptr_n   = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
      state_n = GAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant_q <= '0;
      ready_q <= '0;
      dat_q   <= 8'hFF;
      last_q  <= 1'b0;
      st_q    <= 1'b0;
      done_q  <= 1'b0;
      gcnt    <= '0;
`ifdef UART_TX_SCHED_CHKSUM_EN
      chk_q    <= 8'h00;
      chk_sent <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gidx    <= gidx_n;
      grant_q <= grant_n;
      ready_q <= ready_n;
      dat_q   <= dat_n;
      last_q  <= last_n;
      st_q    <= st_n;
      done_q  <= done_n;
      gcnt    <= gcnt_n;
`ifdef UART_TX_SCHED_CHKSUM_EN
      chk_q    <= chk_n;
      chk_sent <= chk_sent_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: requester drivers, a behavioural transmitter
// and a packet-level round-robin reference model.
module tb_uart_tx_sched;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned GAP_TACTS = 3;
  localparam int          BT        = 4;
  localparam int          FRAME     = 10 * BT;
`ifdef UART_TX_SCHED_CHKSUM_EN
  localparam int          CHK_EXTRA = 1;
`else
  localparam int          CHK_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_st;
  logic [7:0] tx_dat;
  logic       tx_busy = 1'b0;
  logic       tx_ce_tact = 1'b0;
  logic       tx_ce_stop = 1'b0;
  logic       pkt_done;

  uart_tx_sched_if #(.N_REQ(N_REQ)) req_if ();

  uart_tx_sched #(.N_REQ(N_REQ), .GAP_TACTS(GAP_TACTS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_if.slave),
    .tx_st      (tx_st),
    .tx_dat     (tx_dat),
    .tx_busy    (tx_busy),
    .tx_ce_tact (tx_ce_tact),
    .tx_ce_stop (tx_ce_stop),
    .pkt_done   (pkt_done)
  );

  always #10 clk = ~clk;

  typedef struct { logic [7:0] d; logic last; int delay; } txn_t;
  typedef struct { logic [7:0] d; int idx; } frm_t;

  txn_t       rq [N_REQ][$];
  frm_t       obs_q[$];
  frm_t       exp_q[$];
  int         gap_q[$];
  int         b2b_q[$];
  int         mdl_len [N_REQ][$];
  logic [7:0] mdl_byte [N_REQ][$];
  logic [7:0] pkt[$];
  int         mdl_ptr = 0;
  int         exp_pkts = 0;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, st_cnt = 0, done_cnt = 0;
  int st_busy_viol = 0, ready_viol = 0, dat_unstable = 0;
  int rem = 0, tact_ph = 0, tacts_since = 0, last_stop_cyc = -1000;
  logic [7:0]       frame_dat = 8'hFF;
  logic [N_REQ-1:0] hs_pend = '0;

  function automatic int oh_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Per-cycle bench engine: requester drivers, transmitter model and monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N_REQ; i++)
        if (hs_pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < N_REQ; i++) begin
        if (rq[i].size() > 0 && rq[i][0].delay > 0) begin
          txn_t t;
          t = rq[i][0];
          t.delay--;
          rq[i][0] = t;
          req_if.req_valid[i] = 1'b0;
        end else if (rq[i].size() > 0) begin
          req_if.req_valid[i]       = 1'b1;
          req_if.req_dat[8*i +: 8]  = rq[i][0].d;
          req_if.req_last[i]        = rq[i][0].last;
        end else begin
          req_if.req_valid[i]       = 1'b0;
          req_if.req_dat[8*i +: 8]  = 8'h00;
          req_if.req_last[i]        = 1'b0;
        end
      end
      if (rem > 0) rem--;
      if (tx_st) begin
        if (rem > 0) st_busy_viol++;
        rem = FRAME;
      end
      tx_busy    = (rem > 0);
      tx_ce_stop = (rem == 1);
      tact_ph    = (tact_ph + 1) % BT;
      tx_ce_tact = (tact_ph == 0);
      if (!rst_n) frame_dat = 8'hFF;
      if (tx_st) begin
        obs_q.push_back('{d: tx_dat, idx: oh_idx(req_if.grant)});
        gap_q.push_back(tacts_since);
        b2b_q.push_back(cyc - last_stop_cyc);
        st_cnt++;
        frame_dat = tx_dat;
      end else if (rem > 0 && tx_dat !== frame_dat) begin
        dat_unstable++;
      end
      if (pkt_done === 1'b1) done_cnt++;
      if ((req_if.req_ready & ~req_if.grant) != '0 || !$onehot0(req_if.req_ready)) ready_viol++;
      if (tx_ce_stop) begin
        tacts_since   = 0;
        last_stop_cyc = cyc;
      end else if (tx_ce_tact) begin
        tacts_since++;
      end
      hs_pend = req_if.req_ready & req_if.req_valid;
    end
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation stalled at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_q.delete();
    gap_q.delete();
    b2b_q.delete();
    done_cnt = 0;
  endtask

  task automatic push_pkt(input int i, input int stall_at, input int stall_len, input bit to_model);
    for (int j = 0; j < pkt.size(); j++) begin
      rq[i].push_back('{d: pkt[j], last: (j == pkt.size() - 1), delay: (j == stall_at) ? stall_len : 0});
      if (to_model) mdl_byte[i].push_back(pkt[j]);
    end
    if (to_model) mdl_len[i].push_back(pkt.size());
    pkt.delete();
  endtask

  // Reference: round-robin over whole packets, one frame per byte plus optional XOR frame
  task automatic build_expected();
    int p;
    int sel;
    logic [7:0] x;
    logic [7:0] b;
    p = mdl_ptr;
    exp_pkts = 0;
    forever begin
      sel = -1;
      for (int k = 0; k < N_REQ; k++)
        if (sel < 0 && mdl_len[(p + k) % N_REQ].size() > 0) sel = (p + k) % N_REQ;
      if (sel < 0) break;
      x = 8'h00;
      repeat (mdl_len[sel].pop_front()) begin
        b = mdl_byte[sel].pop_front();
        x = x ^ b;
        exp_q.push_back('{d: b, idx: sel});
      end
      if (CHK_EXTRA != 0) exp_q.push_back('{d: x, idx: sel});
      p = (sel + 1) % N_REQ;
      exp_pkts++;
    end
    mdl_ptr = p;
  endtask

  task automatic run_and_check(input string nm, input int budget);
    int c;
    int n;
    build_expected();
    c = 0;
    while (done_cnt < exp_pkts && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (GAP_TACTS * BT + 8) @(negedge clk);
    n_cmp++;
    if (done_cnt !== exp_pkts) begin
      n_bad++;
      $display("FAIL %s pkt_done count: got %0d expected %0d", nm, done_cnt, exp_pkts);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s frame count: got %0d expected %0d", nm, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      n_cmp++;
      if (obs_q[j].d !== exp_q[j].d) begin
        n_bad++;
        $display("FAIL %s frame %0d byte: got %02h expected %02h", nm, j, obs_q[j].d, exp_q[j].d);
      end
      n_cmp++;
      if (obs_q[j].idx !== exp_q[j].idx) begin
        n_bad++;
        $display("FAIL %s frame %0d owner: got %0d expected %0d", nm, j, obs_q[j].idx, exp_q[j].idx);
      end
    end
    n_cmp++;
    if (req_if.grant !== '0) begin
      n_bad++;
      $display("FAIL %s grant after packets: got %b expected 0", nm, req_if.grant);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    n_cmp++;
    if (tx_st !== 1'b0) begin n_bad++; $display("FAIL %s tx_st: got %b expected 0", nm, tx_st); end
    n_cmp++;
    if (tx_dat !== 8'hFF) begin n_bad++; $display("FAIL %s tx_dat: got %02h expected ff", nm, tx_dat); end
    n_cmp++;
    if (req_if.grant !== '0) begin n_bad++; $display("FAIL %s grant: got %b expected 0", nm, req_if.grant); end
    n_cmp++;
    if (req_if.req_ready !== '0) begin n_bad++; $display("FAIL %s req_ready: got %b expected 0", nm, req_if.req_ready); end
    n_cmp++;
    if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL %s pkt_done: got %b expected 0", nm, pkt_done); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_two_simul();
    clear_obs();
    pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom)); push_pkt(0, -1, 0, 1'b1);
    pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom)); push_pkt(2, -1, 0, 1'b1);
    run_and_check("two_simul", 3000);
    n_cmp++;
    if (b2b_q.size() < 2 || b2b_q[1] !== 2) begin
      n_bad++;
      $display("FAIL back_to_back st spacing: got %0d expected 2", (b2b_q.size() > 1) ? b2b_q[1] : -1);
    end
    n_cmp++;
    if (gap_q.size() <= 2 + CHK_EXTRA || gap_q[2 + CHK_EXTRA] !== int'(GAP_TACTS)) begin
      n_bad++;
      $display("FAIL two_simul gap tacts: got %0d expected %0d",
               (gap_q.size() > 2 + CHK_EXTRA) ? gap_q[2 + CHK_EXTRA] : -1, GAP_TACTS);
    end
    clear_obs();
    pkt.push_back(8'h5A); push_pkt(1, -1, 0, 1'b1);
    pkt.push_back(8'hC3); push_pkt(3, -1, 0, 1'b1);
    run_and_check("ptr_after_two", 3000);
    n_cmp++;
    if (obs_q.size() < 1 || obs_q[0].idx !== 3) begin
      n_bad++;
      $display("FAIL ptr_after_two first owner: got %0d expected 3", (obs_q.size() > 0) ? obs_q[0].idx : -1);
    end
  endtask

  task automatic test_single();
    clear_obs();
    pkt.push_back(8'hA5);
    push_pkt(0, -1, 0, 1'b1);
    run_and_check("single", 2000);
    n_cmp++;
    if (obs_q.size() !== 1 + CHK_EXTRA || obs_q[0].d !== 8'hA5) begin
      n_bad++;
      $display("FAIL single frames: got %0d frames first %02h expected %0d frames first a5",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].d : 8'h00, 1 + CHK_EXTRA);
    end
  endtask

  task automatic test_stall();
    int c;
    int st0;
    clear_obs();
    pkt.push_back(8'h3C); pkt.push_back(8'hE7);
    push_pkt(1, 1, 5000, 1'b1);
    c = 0;
    while (obs_q.size() < 1 && c < 500) begin @(negedge clk); c++; end
    repeat (FRAME + 200) @(negedge clk);
    st0 = st_cnt;
    repeat (2000) @(negedge clk);
    n_cmp++;
    if (req_if.grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL stall grant held: got %b expected 0010", req_if.grant);
    end
    n_cmp++;
    if (st_cnt !== st0 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stall line idle: got %0d starts busy=%b expected 0 starts busy=0", st_cnt - st0, tx_busy);
    end
    run_and_check("stall", 8000);
  endtask

  task automatic test_chksum();
    clear_obs();
    pkt.push_back(8'h12); pkt.push_back(8'h34);
    push_pkt(2, -1, 0, 1'b1);
    run_and_check("chksum", 3000);
    n_cmp++;
`ifdef UART_TX_SCHED_CHKSUM_EN
    if (obs_q.size() !== 3 || obs_q[2].d !== 8'h26) begin
      n_bad++;
      $display("FAIL chksum frame: got %0d frames last %02h expected 3 frames last 26",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].d : 8'h00);
    end
`else
    if (obs_q.size() !== 2) begin
      n_bad++;
      $display("FAIL chksum frames: got %0d expected 2", obs_q.size());
    end
`endif
  endtask

  task automatic test_gap();
    clear_obs();
    pkt.push_back(8'h81); push_pkt(1, -1, 0, 1'b1);
    pkt.push_back(8'h18); push_pkt(2, -1, 0, 1'b1);
    run_and_check("gap", 3000);
    n_cmp++;
    if (gap_q.size() <= 1 + CHK_EXTRA || gap_q[1 + CHK_EXTRA] !== int'(GAP_TACTS)) begin
      n_bad++;
      $display("FAIL gap tacts: got %0d expected %0d",
               (gap_q.size() > 1 + CHK_EXTRA) ? gap_q[1 + CHK_EXTRA] : -1, GAP_TACTS);
    end
  endtask

  task automatic test_random();
    int np;
    int len;
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      np = 0;
      for (int i = 0; i < N_REQ; i++) begin
        repeat ($urandom_range(0, 2)) begin
          len = $urandom_range(1, 4);
          repeat (len) pkt.push_back(8'($urandom));
          push_pkt(i, -1, 0, 1'b1);
          np++;
        end
      end
      if (np == 0) begin
        pkt.push_back(8'($urandom));
        push_pkt($urandom_range(0, N_REQ - 1), -1, 0, 1'b1);
      end
      run_and_check("random", 20000);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_obs();
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    push_pkt(0, -1, 0, 1'b0);
    c = 0;
    while (obs_q.size() < 1 && c < 2000) begin @(negedge clk); c++; end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
    mdl_ptr = 0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    clear_obs();
    st_busy_viol = 0;
    pkt.push_back(8'h9D);
    push_pkt(2, -1, 0, 1'b1);
    run_and_check("reset_mid", 3000);
    n_cmp++;
    if (st_busy_viol !== 0) begin
      n_bad++;
      $display("FAIL reset_mid start while busy: got %0d expected 0", st_busy_viol);
    end
  endtask

  initial begin
    req_if.req_valid = '0;
    req_if.req_dat   = '0;
    req_if.req_last  = '0;
    test_reset();
    test_two_simul();
    test_single();
    test_stall();
    test_chksum();
    test_gap();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (ready_viol !== 0) begin n_bad++; $display("FAIL ready only to grantee: got %0d violations expected 0", ready_viol); end
    n_cmp++;
    if (dat_unstable !== 0) begin n_bad++; $display("FAIL tx_dat stable in frame: got %0d changes expected 0", dat_unstable); end
    n_cmp++;
    if (st_busy_viol !== 0) begin n_bad++; $display("FAIL start while busy: got %0d expected 0", st_busy_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
